id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 183 ++++++++++++++++++
 tb/tb_id_ex_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with bubble insertion, register-file write bypass,
// EX operand forwarding and stall/bubble statistics.
module id_ex_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic        id_mem_write,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_imm,
    input  logic [31:0] id_rs1_data,
    input  logic [31:0] id_rs2_data,
    input  logic [3:0]  id_alu_op,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        hazard_stall,
    input  logic        hazard_flush,
    input  logic [1:0]  hazard_forwardA,
    input  logic [1:0]  hazard_forwardB,
    input  logic [31:0] ex_mem_result,
    input  logic [31:0] mem_wb_result,
    output logic [4:0]  ID_EX_Rs1,
    output logic [4:0]  ID_EX_Rs2,
    output logic [4:0]  ID_EX_Rd,
    output logic        ex_valid,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_imm,
    output logic [31:0] ex_op_a,
    output logic [31:0] ex_op_b,
    output logic [3:0]  ex_alu_op,
    output logic        id_ready,
    output logic [1:0]  stage_state,
    output logic [3:0]  stall_cnt,
    output logic        stall_long,
    output logic [15:0] bubble_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        STALL = 2'b01,
        FLUSH = 2'b10
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic        valid_q, valid_d, reg_write_q, reg_write_d;
    logic        mem_read_q, mem_read_d, mem_write_q, mem_write_d;
    logic [31:0] pc_q, pc_d, imm_q, imm_d;
    logic [31:0] rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
    logic [3:0]  alu_op_q, alu_op_d;
    logic [3:0]  stall_cnt_q, stall_cnt_d;
    logic        stall_long_q, stall_long_d;
    logic [15:0] bubble_cnt_q, bubble_cnt_d;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // A write landing in the register file this cycle is not yet visible on the read port.
    function automatic logic [31:0] wb_bypass(input logic [4:0] rs, input logic [31:0] rf_data,
                                              input logic we, input logic [4:0] rd,
                                              input logic [31:0] wdata);
        return (we && rd != 5'd0 && rd == rs) ? wdata : rf_data;
    endfunction

    function automatic logic [31:0] fwd_sel(input logic [1:0] sel, input logic [31:0] captured,
                                            input logic [31:0] exm, input logic [31:0] mwb);
        case (sel)
            2'b10:   return exm;
            2'b01:   return mwb;
            default: return captured;
        endcase
    endfunction

    always_comb begin
        state_d = RUN;
        if (hazard_flush)
            state_d = FLUSH;
        else if (hazard_stall)
            state_d = STALL;
    end

    always_comb begin
        rs1_d        = 5'd0;
        rs2_d        = 5'd0;
        rd_d         = 5'd0;
        valid_d      = 1'b0;
        reg_write_d  = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        pc_d         = 32'd0;
        imm_d        = 32'd0;
        rs1_data_d   = 32'd0;
        rs2_data_d   = 32'd0;
        alu_op_d     = 4'd0;
        stall_cnt_d  = 4'd0;
        bubble_cnt_d = bubble_cnt_q;
        if (state_d == RUN) begin
            rs1_d       = id_rs1;
            rs2_d       = id_rs2;
            rd_d        = id_rd;
            valid_d     = id_valid;
            reg_write_d = id_valid & id_reg_write;
            mem_read_d  = id_valid & id_mem_read;
            mem_write_d = id_valid & id_mem_write;
            pc_d        = id_pc;
            imm_d       = id_imm;
            rs1_data_d  = wb_bypass(id_rs1, id_rs1_data, wb_we, wb_rd, wb_data);
            rs2_data_d  = wb_bypass(id_rs2, id_rs2_data, wb_we, wb_rd, wb_data);
            alu_op_d    = id_alu_op;
        end else begin
            bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
        if (state_d == STALL)
            stall_cnt_d = sat_inc4(stall_cnt_q);
        stall_long_d = (stall_cnt_d >= 4'd8);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RUN;
            rs1_q        <= 5'd0;
            rs2_q        <= 5'd0;
            rd_q         <= 5'd0;
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            pc_q         <= 32'd0;
            imm_q        <= 32'd0;
            rs1_data_q   <= 32'd0;
            rs2_data_q   <= 32'd0;
            alu_op_q     <= 4'd0;
            stall_cnt_q  <= 4'd0;
            stall_long_q <= 1'b0;
            bubble_cnt_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            rd_q         <= rd_d;
            valid_q      <= valid_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            pc_q         <= pc_d;
            imm_q        <= imm_d;
            rs1_data_q   <= rs1_data_d;
            rs2_data_q   <= rs2_data_d;
            alu_op_q     <= alu_op_d;
            stall_cnt_q  <= stall_cnt_d;
            stall_long_q <= stall_long_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign id_ready     = ~hazard_stall | hazard_flush;
    assign stage_state  = state_q;
    assign ID_EX_Rs1    = rs1_q;
    assign ID_EX_Rs2    = rs2_q;
    assign ID_EX_Rd     = rd_q;
    assign ex_valid     = valid_q;
    assign ex_reg_write = reg_write_q;
    assign ex_mem_read  = mem_read_q;
    assign ex_mem_write = mem_write_q;
    assign ex_pc        = pc_q;
    assign ex_imm       = imm_q;
    assign ex_alu_op    = alu_op_q;
    assign ex_op_a      = fwd_sel(hazard_forwardA, rs1_data_q, ex_mem_result, mem_wb_result);
    assign ex_op_b      = fwd_sel(hazard_forwardB, rs2_data_q, ex_mem_result, mem_wb_result);
    assign stall_cnt    = stall_cnt_q;
    assign stall_long   = stall_long_q;
    assign bubble_cnt   = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, pass-through, forwarding, bypass,
// stall/flush bubbles, reset abort and bubble counter wrap.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, id_reg_write, id_mem_read, id_mem_write;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_pc, id_imm, id_rs1_data, id_rs2_data;
    logic [3:0]  id_alu_op;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        hazard_stall, hazard_flush;
    logic [1:0]  hazard_forwardA, hazard_forwardB;
    logic [31:0] ex_mem_result, mem_wb_result;
    logic [4:0]  ID_EX_Rs1, ID_EX_Rs2, ID_EX_Rd;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic [31:0] ex_pc, ex_imm, ex_op_a, ex_op_b;
    logic [3:0]  ex_alu_op;
    logic        id_ready;
    logic [1:0]  stage_state;
    logic [3:0]  stall_cnt;
    logic        stall_long;
    logic [15:0] bubble_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_pc(id_pc), .id_imm(id_imm), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_alu_op(id_alu_op), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .hazard_stall(hazard_stall), .hazard_flush(hazard_flush),
        .hazard_forwardA(hazard_forwardA), .hazard_forwardB(hazard_forwardB),
        .ex_mem_result(ex_mem_result), .mem_wb_result(mem_wb_result),
        .ID_EX_Rs1(ID_EX_Rs1), .ID_EX_Rs2(ID_EX_Rs2), .ID_EX_Rd(ID_EX_Rd),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_alu_op(ex_alu_op),
        .id_ready(id_ready), .stage_state(stage_state), .stall_cnt(stall_cnt),
        .stall_long(stall_long), .bubble_cnt(bubble_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_instr();
        id_valid = 1'b1; id_reg_write = 1'b1; id_mem_read = 1'b1; id_mem_write = 1'b0;
        id_rs1 = 5'd3; id_rs2 = 5'd4; id_rd = 5'd7;
        id_pc = 32'h100; id_imm = 32'h20; id_rs1_data = 32'h11; id_rs2_data = 32'h22;
        id_alu_op = 4'd5;
    endtask

    task automatic test_reset();
        load_instr();
        wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
        hazard_stall = 1'b1; hazard_flush = 1'b0;
        hazard_forwardA = 2'b00; hazard_forwardB = 2'b00;
        ex_mem_result = 32'hAA; mem_wb_result = 32'hBB;
        reset = 1'b1;
        step(); step();
        checks++; if (id_ready !== 1'b0) begin failures++; $display("FAIL reset_ready_stall got=%b exp=0", id_ready); end
        hazard_flush = 1'b1; #1;
        checks++; if (id_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_flush got=%b exp=1", id_ready); end
        step();
        checks++; if (stage_state !== 2'b00) begin failures++; $display("FAIL reset_state got=%0d exp=0", stage_state); end
        checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0) begin failures++; $display("FAIL reset_ctrl got=%b%b%b exp=000", ex_valid, ex_reg_write, ex_mem_read); end
        checks++; if (ID_EX_Rs1 !== 5'd0 || ID_EX_Rd !== 5'd0) begin failures++; $display("FAIL reset_idx got=%0d/%0d exp=0/0", ID_EX_Rs1, ID_EX_Rd); end
        checks++; if (ex_pc !== 32'd0 || ex_imm !== 32'd0 || ex_op_a !== 32'd0) begin failures++; $display("FAIL reset_data got=%h/%h/%h exp=0", ex_pc, ex_imm, ex_op_a); end
        checks++; if (stall_cnt !== 4'd0 || stall_long !== 1'b0 || bubble_cnt !== 16'd0) begin failures++; $display("FAIL reset_counters got=%0d/%b/%0d exp=0/0/0", stall_cnt, stall_long, bubble_cnt); end
        hazard_stall = 1'b0; hazard_flush = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_pass_through();
        load_instr();
        step();
        checks++; if (ex_valid !== 1'b1) begin failures++; $display("FAIL pass_valid got=%b exp=1", ex_valid); end
        checks++; if (ID_EX_Rs1 !== 5'd3 || ID_EX_Rs2 !== 5'd4 || ID_EX_Rd !== 5'd7) begin failures++; $display("FAIL pass_idx got=%0d/%0d/%0d exp=3/4/7", ID_EX_Rs1, ID_EX_Rs2, ID_EX_Rd); end
        checks++; if (ex_op_a !== 32'h11 || ex_op_b !== 32'h22) begin failures++; $display("FAIL pass_ops got=%h/%h exp=11/22", ex_op_a, ex_op_b); end
        checks++; if (ex_pc !== 32'h100 || ex_imm !== 32'h20 || ex_alu_op !== 4'd5) begin failures++; $display("FAIL pass_fields got=%h/%h/%0d exp=100/20/5", ex_pc, ex_imm, ex_alu_op); end
        checks++; if (ex_reg_write !== 1'b1 || ex_mem_read !== 1'b1 || ex_mem_write !== 1'b0) begin failures++; $display("FAIL pass_ctrl got=%b%b%b exp=110", ex_reg_write, ex_mem_read, ex_mem_write); end
        checks++; if (bubble_cnt !== 16'd0 || stage_state !== 2'b00 || id_ready !== 1'b1) begin failures++; $display("FAIL pass_status got=%0d/%0d/%b exp=0/0/1", bubble_cnt, stage_state, id_ready); end
    endtask

    task automatic test_forwarding();
        hazard_forwardA = 2'b10; #1;
        checks++; if (ex_op_a !== 32'hAA) begin failures++; $display("FAIL fwdA_exmem got=%h exp=aa", ex_op_a); end
        hazard_forwardA = 2'b01; #1;
        checks++; if (ex_op_a !== 32'hBB) begin failures++; $display("FAIL fwdA_memwb got=%h exp=bb", ex_op_a); end
        hazard_forwardA = 2'b11; #1;
        checks++; if (ex_op_a !== 32'h11) begin failures++; $display("FAIL fwdA_11 got=%h exp=11", ex_op_a); end
        hazard_forwardB = 2'b10; #1;
        checks++; if (ex_op_b !== 32'hAA) begin failures++; $display("FAIL fwdB_exmem got=%h exp=aa", ex_op_b); end
        hazard_forwardB = 2'b01; #1;
        checks++; if (ex_op_b !== 32'hBB) begin failures++; $display("FAIL fwdB_memwb got=%h exp=bb", ex_op_b); end
        hazard_forwardA = 2'b00; hazard_forwardB = 2'b00; #1;
        checks++; if (ex_op_b !== 32'h22) begin failures++; $display("FAIL fwdB_00 got=%h exp=22", ex_op_b); end
    endtask

    task automatic test_invalid();
        id_valid = 1'b0; id_mem_write = 1'b1; id_rd = 5'd9;
        step();
        checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0 || ex_mem_write !== 1'b0) begin failures++; $display("FAIL invalid_ctrl got=%b%b%b%b exp=0000", ex_valid, ex_reg_write, ex_mem_read, ex_mem_write); end
        checks++; if (ID_EX_Rd !== 5'd9 || ex_pc !== 32'h100) begin failures++; $display("FAIL invalid_fields got=%0d/%h exp=9/100", ID_EX_Rd, ex_pc); end
        checks++; if (bubble_cnt !== 16'd0) begin failures++; $display("FAIL invalid_nobubble got=%0d exp=0", bubble_cnt); end
        id_valid = 1'b1; id_mem_write = 1'b0;
    endtask

    task automatic test_bypass();
        id_rs1 = 5'd5; id_rs2 = 5'd5; id_rs1_data = 32'h2; id_rs2_data = 32'h1;
        wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h77;
        step();
        checks++; if (ex_op_b !== 32'h77 || ex_op_a !== 32'h77) begin failures++; $display("FAIL bypass_hit got=%h/%h exp=77/77", ex_op_a, ex_op_b); end
        wb_rd = 5'd0;
        step();
        checks++; if (ex_op_b !== 32'h1 || ex_op_a !== 32'h2) begin failures++; $display("FAIL bypass_rd0 got=%h/%h exp=2/1", ex_op_a, ex_op_b); end
        id_rs2 = 5'd0;
        step();
        checks++; if (ex_op_b !== 32'h1) begin failures++; $display("FAIL bypass_x0 got=%h exp=1", ex_op_b); end
        wb_we = 1'b0; wb_rd = 5'd5; id_rs2 = 5'd5;
        step();
        checks++; if (ex_op_b !== 32'h1) begin failures++; $display("FAIL bypass_nowe got=%h exp=1", ex_op_b); end
    endtask

    task automatic test_stall();
        int exp_cnt;
        hazard_stall = 1'b1; #1;
        checks++; if (id_ready !== 1'b0) begin failures++; $display("FAIL stall_ready got=%b exp=0", id_ready); end
        for (int i = 1; i <= 17; i++) begin
            step();
            exp_cnt = (i > 15) ? 15 : i;
            checks++; if (stall_cnt !== 4'(exp_cnt)) begin failures++; $display("FAIL stall_cnt_%0d got=%0d exp=%0d", i, stall_cnt, exp_cnt); end
            checks++; if (stall_long !== (i >= 8)) begin failures++; $display("FAIL stall_long_%0d got=%b exp=%b", i, stall_long, (i >= 8)); end
            checks++; if (bubble_cnt !== 16'(i)) begin failures++; $display("FAIL stall_bubbles_%0d got=%0d exp=%0d", i, bubble_cnt, i); end
            checks++; if (ex_valid !== 1'b0 || ID_EX_Rs1 !== 5'd0 || ex_pc !== 32'd0 || ex_op_a !== 32'd0 || stage_state !== 2'b01) begin failures++; $display("FAIL stall_bubble_%0d got=%b/%0d/%h/%h/%0d exp=0/0/0/0/1", i, ex_valid, ID_EX_Rs1, ex_pc, ex_op_a, stage_state); end
        end
        hazard_stall = 1'b0;
        step();
        checks++; if (stall_cnt !== 4'd0 || stall_long !== 1'b0 || stage_state !== 2'b00) begin failures++; $display("FAIL stall_release got=%0d/%b/%0d exp=0/0/0", stall_cnt, stall_long, stage_state); end
        checks++; if (ex_valid !== 1'b1 || bubble_cnt !== 16'd17) begin failures++; $display("FAIL stall_resume got=%b/%0d exp=1/17", ex_valid, bubble_cnt); end
    endtask

    task automatic test_stall_flush();
        hazard_stall = 1'b1;
        step(); step();
        checks++; if (stall_cnt !== 4'd2) begin failures++; $display("FAIL sf_pre got=%0d exp=2", stall_cnt); end
        hazard_flush = 1'b1; #1;
        checks++; if (id_ready !== 1'b1) begin failures++; $display("FAIL sf_ready got=%b exp=1", id_ready); end
        step();
        checks++; if (stage_state !== 2'b10 || stall_cnt !== 4'd0) begin failures++; $display("FAIL sf_state got=%0d/%0d exp=2/0", stage_state, stall_cnt); end
        checks++; if (ex_valid !== 1'b0 || ID_EX_Rd !== 5'd0 || bubble_cnt !== 16'd20) begin failures++; $display("FAIL sf_bubble got=%b/%0d/%0d exp=0/0/20", ex_valid, ID_EX_Rd, bubble_cnt); end
        hazard_stall = 1'b0; hazard_flush = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_stall();
        hazard_stall = 1'b1;
        repeat (5) step();
        checks++; if (stall_cnt !== 4'd5 || bubble_cnt !== 16'd25) begin failures++; $display("FAIL rms_pre got=%0d/%0d exp=5/25", stall_cnt, bubble_cnt); end
        reset = 1'b1;
        step();
        checks++; if (stage_state !== 2'b00 || stall_cnt !== 4'd0 || bubble_cnt !== 16'd0 || ex_valid !== 1'b0 || ex_op_a !== 32'd0) begin failures++; $display("FAIL rms_reset got=%0d/%0d/%0d/%b/%h exp=0/0/0/0/0", stage_state, stall_cnt, bubble_cnt, ex_valid, ex_op_a); end
        reset = 1'b0; hazard_stall = 1'b0;
        step();
        checks++; if (stage_state !== 2'b00 || ex_valid !== 1'b1 || bubble_cnt !== 16'd0) begin failures++; $display("FAIL rms_resume got=%0d/%b/%0d exp=0/1/0", stage_state, ex_valid, bubble_cnt); end
    endtask

    task automatic test_bubble_wrap();
        hazard_flush = 1'b1;
        repeat (65535) @(posedge clk);
        #1;
        checks++; if (bubble_cnt !== 16'hFFFF) begin failures++; $display("FAIL wrap_pre got=%h exp=ffff", bubble_cnt); end
        step();
        checks++; if (bubble_cnt !== 16'h0000) begin failures++; $display("FAIL wrap_post got=%h exp=0000", bubble_cnt); end
        hazard_flush = 1'b0;
        step();
        checks++; if (bubble_cnt !== 16'h0000 || stage_state !== 2'b00) begin failures++; $display("FAIL wrap_hold got=%h/%0d exp=0000/0", bubble_cnt, stage_state); end
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_forwarding();
        test_invalid();
        test_bypass();
        test_stall();
        test_stall_flush();
        test_reset_mid_stall();
        test_bubble_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
